// File: rtl/prpg_pkg.sv
// prpg_pkg: shared widths, MISR state type and signature update for PRPG and its compactor
package prpg_pkg;
  localparam int TAP_W = 7;
  localparam int SIG_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} misr_state_t;
  function automatic logic [0:SIG_W-1] misr_next(input logic [0:SIG_W-1] s, input logic [TAP_W-1:0] tap, input logic [0:SIG_W-1] d);
    logic [0:SIG_W-1] n;
    n[0] = s[SIG_W-1] ^ d[0];
    for (int i = 1; i < SIG_W; i++) n[i] = (tap[SIG_W-1-i] ? s[SIG_W-1] ^ s[i-1] : s[i-1]) ^ d[i];
    return n;
  endfunction
endpackage

// File: rtl/prpg_misr_ctrl.sv
// prpg_misr_ctrl: run FSM, beat counter and pattern handshake for the signature compactor
module prpg_misr_ctrl
  import prpg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cfg_we,
  input  logic             pat_valid,
  input  logic [CNT_W-1:0] num,
  output logic             pat_ready,
  output logic             busy,
  output logic             done,
  output logic             load,
  output logic             absorb,
  output logic             check
);
  misr_state_t state_q, state_d;
  logic [CNT_W-1:0] count_q;
  assign pat_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == CHECK;
  assign done = state_q == DONE;
  assign check = state_q == CHECK;
  assign load = start & ~busy;
  assign absorb = pat_ready & pat_valid;
  // next state: start beats the DONE->IDLE return; the final beat goes straight to CHECK
  always_comb begin
    state_d = state_q;
    if (load) state_d = (num == '0) ? CHECK : RUN;
    else if (done && cfg_we) state_d = IDLE;
    else if (absorb && count_q + CNT_W'(1) == num) state_d = CHECK;
    else if (check) state_d = DONE;
  end
  // state register and count of accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= load ? '0 : absorb ? count_q + CNT_W'(1) : count_q;
    end
  end
endmodule

// File: rtl/prpg_misr.sv
// prpg_misr: compacts PRPG patterns into an 8-bit MISR and checks the result against a golden signature
module prpg_misr
  import prpg_pkg::*;
#(
  parameter int W     = SIG_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic [0:W-1]     cfg_seed,
  input  logic [0:W-1]     cfg_golden,
  input  logic [CNT_W-1:0] cfg_num,
  input  logic             start,
  input  logic             pat_valid,
  input  logic [0:W-1]     pat,
  output logic             pat_ready,
  output logic [0:W-1]     sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);
  logic [TAP_W-1:0] tap_q;
  logic [0:W-1] seed_q, golden_q;
  logic [CNT_W-1:0] num_q;
  logic cfg_ok, load, absorb, check;
  assign cfg_ok = cfg_we & ~busy;
  prpg_misr_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_we(cfg_ok),
    .pat_valid(pat_valid),
    .num(cfg_ok ? cfg_num : num_q),
    .pat_ready(pat_ready),
    .busy(busy),
    .done(done),
    .load(load),
    .absorb(absorb),
    .check(check)
  );
  // configuration registers, writable only while idle or done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
      seed_q <= '0;
      golden_q <= '0;
      num_q <= '0;
    end else if (cfg_ok) begin
      tap_q <= cfg_tap;
      seed_q <= cfg_seed;
      golden_q <= cfg_golden;
      num_q <= cfg_num;
    end
  end
  // signature: seeded on start (new seed when written in the same cycle), updated per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig <= '0;
    else if (load) sig <= cfg_ok ? cfg_seed : seed_q;
    else if (absorb) sig <= misr_next(sig, tap_q, pat);
  end
  // verdict latched during the single CHECK cycle, cleared by a new run or reconfiguration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pass <= 1'b0;
    else if (load || cfg_ok) pass <= 1'b0;
    else if (check) pass <= sig == golden_q;
  end
endmodule

// File: tb/tb_prpg_misr.sv
// tb_prpg_misr: randomized self-checking bench against a Galois-LFSR arithmetic model of the MISR
module tb_prpg_misr;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0, start = 1'b0, pat_valid = 1'b0;
  logic [6:0] cfg_tap = '0;
  logic [0:7] cfg_seed = '0, cfg_golden = '0, pat = '0;
  logic [7:0] cfg_num = '0;
  logic pat_ready, busy, done, pass;
  logic [0:7] sig;
  int n_tests = 0, n_fail = 0;
  logic [6:0] m_tap;
  logic [7:0] m_seed, m_golden;
  int m_num;
  logic [7:0] pats[$];
  bit gapseq[5] = '{1, 0, 0, 1, 1};

  always #5 clk = ~clk;

  prpg_misr dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
    .cfg_golden(cfg_golden), .cfg_num(cfg_num), .start(start), .pat_valid(pat_valid),
    .pat(pat), .pat_ready(pat_ready), .sig(sig), .busy(busy), .done(done), .pass(pass)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bit 0 of the integer view is s[7]: shift right, fold feedback polynomial {1,tap} when s[7] was set
  function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [6:0] tap, input logic [7:0] d);
    return (v >> 1) ^ (v[0] ? {1'b1, tap} : 8'h00) ^ d;
  endfunction

  task automatic run(input bit do_cfg, input bit gapped, input string tag);
    logic [7:0] exp;
    int idx, cyc;
    bit v;
    exp = m_seed;
    foreach (pats[k]) exp = ref_step(exp, m_tap, pats[k]);
    if (do_cfg) begin
      cfg_we = 1; cfg_tap = m_tap; cfg_seed = m_seed; cfg_golden = m_golden; cfg_num = m_num[7:0];
      @(negedge clk);
      cfg_we = 0;
    end
    start = 1;
    @(negedge clk);
    start = 0;
    check({tag, " busy"}, 32'(busy), 1);
    idx = 0; cyc = 0;
    while (idx < m_num && cyc < 200) begin
      check({tag, " ready"}, 32'(pat_ready), 1);
      v = gapped ? gapseq[cyc % 5] : ($urandom_range(0, 2) != 0);
      pat_valid = v;
      pat = v ? pats[idx] : 8'($urandom);
      if (gapped && !v) begin
        cfg_we = 1; start = 1; cfg_num = 8'd1;
        cfg_tap = 7'($urandom); cfg_seed = 8'($urandom); cfg_golden = 8'($urandom);
      end
      @(negedge clk);
      pat_valid = 0; cfg_we = 0; start = 0;
      if (v) idx++;
      cyc++;
    end
    check({tag, " beats"}, idx, m_num);
    check({tag, " ready low in check"}, 32'(pat_ready), 0);
    check({tag, " done low in check"}, 32'(done), 0);
    @(negedge clk);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy low"}, 32'(busy), 0);
    check({tag, " sig"}, 32'(sig), 32'(exp));
    check({tag, " pass"}, 32'(pass), 32'(exp == m_golden));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset sig", 32'(sig), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset pass", 32'(pass), 0);
    check("reset ready", 32'(pat_ready), 0);
    rst_n = 1;
    @(negedge clk);

    m_tap = 0; m_seed = 0; m_golden = 8'h01; m_num = 1; pats = '{8'h01};
    run(1, 0, "t2");
    check("t2 sig const", 32'(sig), 32'h01);

    m_tap = 0; m_seed = 0; m_golden = 8'h00; m_num = 2; pats = '{8'h80, 8'h40};
    run(1, 0, "t3a");
    check("t3a pass const", 32'(pass), 1);
    m_golden = 8'h01;
    run(1, 0, "t3b");
    check("t3b pass const", 32'(pass), 0);

    m_tap = 7'b0100101; m_seed = 8'hFF; m_golden = 8'hDA; m_num = 1; pats = '{8'h00};
    run(1, 0, "t4");
    check("t4 sig const", 32'(sig), 32'hDA);

    m_tap = 7'($urandom); m_seed = 8'hA5; m_golden = 8'hA5; m_num = 0; pats = {};
    run(1, 0, "t5");

    m_tap = 7'($urandom); m_seed = 8'($urandom); m_golden = 8'($urandom); m_num = 3;
    pats = {8'($urandom), 8'($urandom), 8'($urandom)};
    run(1, 1, "t6");
    run(0, 0, "t6 rerun");
    cfg_we = 1;
    @(negedge clk);
    cfg_we = 0;
    check("done cleared by cfg", 32'(done), 0);
    check("idle after cfg", 32'(busy), 0);

    m_tap = 7'($urandom); m_seed = 8'($urandom); m_num = 5;
    cfg_we = 1; cfg_tap = m_tap; cfg_seed = m_seed; cfg_num = 8'd5;
    @(negedge clk);
    cfg_we = 0; start = 1;
    @(negedge clk);
    start = 0; pat_valid = 1; pat = 8'($urandom);
    repeat (2) @(negedge clk);
    pat_valid = 0;
    #2 rst_n = 0;
    #1;
    check("midrun rst sig", 32'(sig), 0);
    check("midrun rst busy", 32'(busy), 0);
    check("midrun rst done", 32'(done), 0);
    check("midrun rst ready", 32'(pat_ready), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int r = 0; r < 25; r++) begin
      m_tap = 7'($urandom); m_seed = 8'($urandom); m_num = $urandom_range(0, 10);
      pats = {};
      for (int k = 0; k < m_num; k++) pats.push_back(8'($urandom));
      m_golden = m_seed;
      foreach (pats[k]) m_golden = ref_step(m_golden, m_tap, pats[k]);
      if ($urandom_range(0, 1) != 0) m_golden = m_golden ^ 8'(1 << $urandom_range(0, 7));
      run(1, 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
